pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 76 +++++++
 tb/tb_pipe_stage_skid.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt/flush_cnt counters.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              accept, pop;

    assign in_ready  = !skid_valid && !rst;
    assign accept    = in_valid && in_ready;
    assign pop       = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || pop) begin
            // main is free this cycle: refill from skid first to keep FIFO order
            main_valid <= skid_valid || accept;
            skid_valid <= 1'b0;
            if (skid_valid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end else if (accept) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (main_valid || skid_valid) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random + directed checks of pipe_stage_skid against a queue model.
module tb_pipe_stage_skid;
    localparam int CW = 3;
    typedef struct {
        logic [1:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_ctrl, out_ctrl;
    logic [31:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    ent_t        q[$];
    logic [31:0] last_data;
    int          m_stall, m_flush;
    int          checks = 0, errors = 0;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
       ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic r, input logic f, input logic v, input logic [1:0] c,
                        input logic [31:0] d, input logic o);
        logic acc, pp;
        ent_t e;
        rst = r; flush = f; in_valid = v; in_ctrl = c; in_data = d; out_ready = o;
        #1;
        chk("in_ready", in_ready, !r && q.size() < 2);
        acc = v && !r && q.size() < 2;
        pp  = q.size() > 0 && o;
        if (r) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (q.size() > 0 && !o && m_stall < (1 << CW) - 1) m_stall++;
            if (f && q.size() > 0 && m_flush < (1 << CW) - 1) m_flush++;
        end
        if (r) begin
            q.delete();
            last_data = '0;
        end else if (f) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.c = c;
                e.d = d;
                q.push_back(e);
            end
        end
        if (q.size() > 0) last_data = q[0].d;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_ctrl", out_ctrl, q.size() > 0 ? q[0].c : 2'd0);
        chk("out_data", out_data, last_data);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    initial begin
        logic        pend, v, o, f, r;
        logic [1:0]  c;
        logic [31:0] d;
        last_data = '0;
        m_stall = 0;
        m_flush = 0;
        // reset held 2 cycles with in_valid high
        step(1, 0, 1, 2'd1, 32'h55, 1);
        step(1, 0, 1, 2'd1, 32'h55, 1);
        chk("rst_data", out_data, 0);
        // streaming
        step(0, 0, 1, 2'd3, 32'h11, 1);
        chk("stream0", out_data, 32'h11);
        step(0, 0, 1, 2'd1, 32'h22, 1);
        chk("stream1", out_data, 32'h22);
        step(0, 0, 1, 2'd2, 32'h33, 1);
        chk("stream2", out_data, 32'h33);
        chk("stream2_ctrl", out_ctrl, 2'd2);
        step(0, 0, 0, 2'd0, 32'h0, 1);
        // backpressure
        step(0, 0, 1, 2'd1, 32'hA, 0);
        step(0, 0, 1, 2'd2, 32'hB, 0);
        chk("full_ready", in_ready, 0);
        step(0, 0, 1, 2'd3, 32'hC, 0);
        step(0, 0, 1, 2'd3, 32'hC, 1);
        chk("bp_b", out_data, 32'hB);
        step(0, 0, 1, 2'd3, 32'hC, 1);
        chk("bp_c", out_data, 32'hC);
        step(0, 0, 0, 2'd0, 32'h0, 1);
        // flush in FULL with a simultaneous input
        step(0, 0, 1, 2'd1, 32'hA, 0);
        step(0, 0, 1, 2'd2, 32'hB, 0);
        step(0, 1, 1, 2'd3, 32'hD, 0);
        chk("flush_ready", in_ready, 1);
        step(0, 0, 0, 2'd0, 32'h0, 1);
        // rst and flush together while BUSY
        step(0, 0, 1, 2'd3, 32'hEE, 0);
        step(1, 1, 0, 2'd0, 32'h0, 0);
        chk("rstflush_data", out_data, 0);
        // stall saturation, one flush with an entry held, then reset
        step(0, 0, 1, 2'd1, 32'h77, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 2'd0, 32'h0, 0);
        step(0, 1, 0, 2'd0, 32'h0, 0);
        step(1, 0, 0, 2'd0, 32'h0, 0);
        // random traffic, holding a refused input stable until taken
        pend = 1'b0;
        v = 1'b0; c = '0; d = '0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(99) < 2);
            f = ($urandom_range(99) < 5);
            o = ($urandom_range(99) < 60);
            if (!pend) begin
                v = ($urandom_range(99) < 70);
                c = 2'($urandom);
                d = $urandom;
            end
            pend = v && !(q.size() < 2 && !r);
            step(r, f, v, c, d, o);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
